alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports req0_valid / req1_valid, input, 1 each, requester N has an operation pending.
REQ-004 SHALL have ports req0_ready / req1_ready, output, 1 each, operation accepted this cycle (handshake = valid & ready).
REQ-005 SHALL have ports reqN_srca / reqN_srcb, input, 32 each, operands of requester N.
REQ-006 SHALL have port reqN_op, input, 4, ALU operation code of requester N.
REQ-007 SHALL have ports alu_srca / alu_srcb / alu_op, output, 32/32/4, drive the shared combinational ALU.
REQ-008 SHALL have ports alu_result / alu_zero / alu_blt / alu_bgt, input, 32/1/1/1, ALU outputs.
REQ-009 SHALL have ports resp0_valid / resp1_valid, output, 1 each, one-cycle pulse: result for requester N.
REQ-010 SHALL have ports resp_result / resp_zero / resp_blt / resp_bgt, output, 32/1/1/1, registered ALU outputs, shared by both requesters.
REQ-011 SHALL have port busy, output, 1, high in EXEC.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 In IDLE or RESP, if any reqN_valid, SHALL assert reqN_ready combinationally for exactly one granted requester, latch its srca/srcb/op, and go to EXEC.
REQ-014 In EXEC, SHALL drive alu_* from the latched operands, register alu_result and flags into resp_*, and go to RESP unconditionally.
REQ-015 In RESP, SHALL pulse respN_valid for the requester granted in that transaction; RESP with no pending valid goes to IDLE.
REQ-016 Latency: handshake in cycle T gives respN_valid in T+2; back-to-back throughput is one operation per 2 cycles.
REQ-017 reqN_ready SHALL be 0 in EXEC, and 0 whenever reqN_valid is 0.
REQ-018 A requester SHALL hold valid and payload until ready; the arbiter SHALL tolerate valid being withdrawn before grant and must not latch it.
REQ-019 resp_* SHALL hold the last value until the next EXEC completes; alu_* SHALL output 0 outside EXEC.
REQ-020 Opcodes SHALL pass through unmodified; undefined opcodes complete normally with whatever the ALU returns (0).
REQ-021 Grant in RESP SHALL apply to a new request in the same cycle as the previous respN_valid pulse (simultaneous response and accept).

Reset
REQ-022 While rst_n is 0, SHALL set: state IDLE, all ready/resp valid 0, resp_* 0, latched operands 0, busy 0, last-grant pointer = 1.
REQ-023 Reset asserted mid-EXEC or mid-RESP SHALL abort the transaction with no respN_valid pulse; operation is lost.

Configuration
REQ-024 With macro ALU_ARB_ROUND_ROBIN_EN defined: on simultaneous valids, SHALL grant the requester not granted last; update the pointer on each handshake.
REQ-025 Without ALU_ARB_ROUND_ROBIN_EN: SHALL use fixed priority, requester 0 over 1; the pointer register is absent.
REQ-026 A single requester SHALL be granted immediately in both configurations.

Verification
REQ-027 Reset, then req0 only with srca=5, srcb=3, op=0010 -> req0_ready at T, resp0_valid at T+2, resp_result=8.
REQ-028 req1 with srca=3, srcb=5, op=0110 -> resp1_valid, resp_result=0xFFFFFFFE, resp_blt=1, zero=0, bgt=0.
REQ-029 Both valid continuously with RR enabled -> grants 0,1,0,1; respN_valid every 2 cycles. Without the macro -> req0 always granted and req1 starved.
REQ-030 rst_n dropped in EXEC -> no resp pulse; after release, state IDLE and resp_result=0.
REQ-031 req0 valid for 1 cycle during EXEC, then dropped -> no grant, no response.
REQ-032 op=1111, srca=0x10000, srcb=0x10000 -> resp_result=0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester channels, the shared ALU port
// and the shared response bus of alu_arbiter.
// master: requester/ALU environment side; slave: the arbiter itself.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic        req0_ready;
  logic        req1_ready;
  logic [31:0] req0_srca;
  logic [31:0] req0_srcb;
  logic [3:0]  req0_op;
  logic [31:0] req1_srca;
  logic [31:0] req1_srcb;
  logic [3:0]  req1_op;

  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_blt;
  logic        alu_bgt;

  logic        resp0_valid;
  logic        resp1_valid;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic        resp_blt;
  logic        resp_bgt;
  logic        busy;

  modport master (
    output req0_valid, req1_valid, req0_srca, req0_srcb, req0_op,
           req1_srca, req1_srcb, req1_op,
           alu_result, alu_zero, alu_blt, alu_bgt,
    input  req0_ready, req1_ready, alu_srca, alu_srcb, alu_op,
           resp0_valid, resp1_valid, resp_result, resp_zero, resp_blt,
           resp_bgt, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_srca, req0_srcb, req0_op,
           req1_srca, req1_srcb, req1_op,
           alu_result, alu_zero, alu_blt, alu_bgt,
    output req0_ready, req1_ready, alu_srca, alu_srcb, alu_op,
           resp0_valid, resp1_valid, resp_result, resp_zero, resp_blt,
           resp_bgt, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// IDLE/RESP accept one request, EXEC drives the ALU and captures its outputs,
// RESP pulses the response valid of the granted requester.
// Optional feature: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration
// on simultaneous requests; otherwise requester 0 has fixed priority.
module alu_arbiter (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q;
  logic [31:0] srca_q;
  logic [31:0] srcb_q;
  logic [3:0]  op_q;
  logic        gnt_q;      // requester owning the transaction in flight
  logic        resp0_q;
  logic        resp1_q;
  logic        busy_q;
  logic [31:0] result_q;
  logic        zero_q;
  logic        blt_q;
  logic        bgt_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic        last_q;     // requester granted by the most recent handshake
`endif

  logic        accept_d;   // a handshake happens this cycle
  logic        sel_d;      // requester selected this cycle (0 or 1)
  logic [31:0] sel_srca_d;
  logic [31:0] sel_srcb_d;
  logic [3:0]  sel_op_d;

  // Arbitration: pick one pending requester while the arbiter can accept.
  always_comb begin
    accept_d = ((state_q == IDLE) || (state_q == RESP)) &&
               (bus.req0_valid || bus.req1_valid);
`ifdef ALU_ARB_ROUND_ROBIN_EN
    sel_d = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
`else
    sel_d = bus.req1_valid && !bus.req0_valid;
`endif
    sel_srca_d = sel_d ? bus.req1_srca : bus.req0_srca;
    sel_srcb_d = sel_d ? bus.req1_srcb : bus.req0_srcb;
    sel_op_d   = sel_d ? bus.req1_op   : bus.req0_op;
  end

  assign bus.req0_ready = accept_d && !sel_d;
  assign bus.req1_ready = accept_d && sel_d;

  // ALU is only driven while executing so it sees zeros otherwise.
  assign bus.alu_srca = (state_q == EXEC) ? srca_q : 32'd0;
  assign bus.alu_srcb = (state_q == EXEC) ? srcb_q : 32'd0;
  assign bus.alu_op   = (state_q == EXEC) ? op_q   : 4'd0;

  assign bus.resp0_valid = resp0_q;
  assign bus.resp1_valid = resp1_q;
  assign bus.resp_result = result_q;
  assign bus.resp_zero   = zero_q;
  assign bus.resp_blt    = blt_q;
  assign bus.resp_bgt    = bgt_q;
  assign bus.busy        = busy_q;

  // Transaction FSM with registered response pulses, busy and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      srca_q   <= 32'd0;
      srcb_q   <= 32'd0;
      op_q     <= 4'd0;
      gnt_q    <= 1'b0;
      resp0_q  <= 1'b0;
      resp1_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      blt_q    <= 1'b0;
      bgt_q    <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q   <= 1'b1;
`endif
    end else begin
      case (state_q)
        EXEC: begin
          result_q <= bus.alu_result;
          zero_q   <= bus.alu_zero;
          blt_q    <= bus.alu_blt;
          bgt_q    <= bus.alu_bgt;
          resp0_q  <= !gnt_q;
          resp1_q  <= gnt_q;
          busy_q   <= 1'b0;
          state_q  <= RESP;
        end
        default: begin
          // IDLE and RESP: response pulse lasts one cycle; accept next request
          resp0_q <= 1'b0;
          resp1_q <= 1'b0;
          if (accept_d) begin
            srca_q  <= sel_srca_d;
            srcb_q  <= sel_srcb_d;
            op_q    <= sel_op_d;
            gnt_q   <= sel_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_q  <= sel_d;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a behavioural ALU,
// a response scoreboard, a vector table and hand-written corner sequences.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        blt;
    logic        bgt;
  } alu_out_t;

  // Reference ALU: AND, OR, ADD, SUB, SLT; every other opcode yields 0.
  function automatic alu_out_t alu_f(input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] op);
    alu_out_t r;
    case (op)
      4'h0:    r.result = a & b;
      4'h1:    r.result = a | b;
      4'h2:    r.result = a + b;
      4'h6:    r.result = a - b;
      4'h7:    r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r.result = 32'd0;
    endcase
    r.zero = (r.result == 32'd0);
    r.blt  = ($signed(a) < $signed(b));
    r.bgt  = ($signed(a) > $signed(b));
    return r;
  endfunction

  alu_out_t alu_now;
  always_comb alu_now = alu_f(bus.alu_srca, bus.alu_srcb, bus.alu_op);
  assign bus.alu_result = alu_now.result;
  assign bus.alu_zero   = alu_now.zero;
  assign bus.alu_blt    = alu_now.blt;
  assign bus.alu_bgt    = alu_now.bgt;

  typedef struct {
    logic        id;
    logic [31:0] result;
    logic        zero;
    logic        blt;
    logic        bgt;
    int          t_hs;
  } exp_t;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        z;
    logic        lt;
    logic        gt;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   resp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic id, input logic [31:0] res, input logic z,
                          input logic lt, input logic gt);
    exp_t e;
    e.id = id; e.result = res; e.zero = z; e.blt = lt; e.bgt = gt; e.t_hs = cyc;
    sb.push_back(e);
    $display("handshake req%0d cycle %0d expect result=%h z=%b lt=%b gt=%b",
             id, cyc, res, z, lt, gt);
  endtask

  task automatic drive_req(input logic id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_srca = a; bus.req1_srcb = b; bus.req1_op = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_srca = a; bus.req0_srcb = b; bus.req0_op = op;
    end
  endtask

  task automatic clr_req(input logic id);
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: per-cycle handshake/ALU invariants and scoreboard comparison.
  always @(negedge clk) begin
    if (rst_n) begin
      n_vec++;
      if ((bus.req0_ready && bus.req1_ready) ||
          (bus.req0_ready && !bus.req0_valid) ||
          (bus.req1_ready && !bus.req1_valid) ||
          (bus.busy && (bus.req0_ready || bus.req1_ready)) ||
          (!bus.busy && (bus.alu_srca != 0 || bus.alu_srcb != 0 || bus.alu_op != 0))) begin
        n_err++;
        $display("FAIL invariant cycle %0d: ready=%b%b valid=%b%b busy=%b alu_a=%h alu_b=%h alu_op=%h, expected legal handshake and idle ALU zero",
                 cyc, bus.req1_ready, bus.req0_ready, bus.req1_valid, bus.req0_valid,
                 bus.busy, bus.alu_srca, bus.alu_srcb, bus.alu_op);
      end
      if (bus.resp0_valid || bus.resp1_valid) begin
        resp_cnt++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_resp cycle %0d: resp=%b%b, expected none",
                   cyc, bus.resp1_valid, bus.resp0_valid);
        end else begin
          mon_e = sb.pop_front();
          if ((bus.resp0_valid && bus.resp1_valid) || (bus.resp1_valid !== mon_e.id) ||
              (bus.resp_result !== mon_e.result) || (bus.resp_zero !== mon_e.zero) ||
              (bus.resp_blt !== mon_e.blt) || (bus.resp_bgt !== mon_e.bgt) ||
              (cyc != mon_e.t_hs + 2)) begin
            n_err++;
            $display("FAIL response: got resp=%b%b res=%h z=%b lt=%b gt=%b cycle %0d, expected req%0d res=%h z=%b lt=%b gt=%b cycle %0d",
                     bus.resp1_valid, bus.resp0_valid, bus.resp_result, bus.resp_zero,
                     bus.resp_blt, bus.resp_bgt, cyc, mon_e.id, mon_e.result,
                     mon_e.zero, mon_e.blt, mon_e.bgt, mon_e.t_hs + 2);
          end else begin
            $display("response req%0d cycle %0d result=%h ok", mon_e.id, cyc, bus.resp_result);
          end
        end
      end
    end
  end

  vec_t vecs [8];

  initial begin
    int       w;
    int       last_t;
    int       cnt0;
    logic     g;
    logic     exp_g;
    alu_out_t m;

    vecs[0] = '{1'b0, 32'd5,        32'd3,        4'h2, 32'd8,        1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 32'd3,        32'd5,        4'h6, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'h10000,    32'h10000,    4'hF, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h0000F0F0, 32'h00000FF0, 4'h0, 32'h000000F0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'h0000F000, 32'h0000000F, 4'h1, 32'h0000F00F, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'd1,        4'h7, 32'd1,        1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'd7,        32'd7,        4'h6, 32'd0,        1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h7FFFFFFF, 32'd1,        4'h2, 32'h80000000, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_srca = '0; bus.req0_srcb = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_srca = '0; bus.req1_srcb = '0; bus.req1_op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    chk("rst_resp0", {31'd0, bus.resp0_valid}, 32'd0);
    chk("rst_resp1", {31'd0, bus.resp1_valid}, 32'd0);
    chk("rst_result", bus.resp_result, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_alu_srca", bus.alu_srca, 32'd0);
    rst_n = 1'b1;

    // Table: one isolated request per vector, granted immediately from IDLE.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      w = 0;
      @(negedge clk);
      while (!(vecs[i].id ? bus.req1_ready : bus.req0_ready) && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!(vecs[i].id ? bus.req1_ready : bus.req0_ready)) begin
        n_vec++; n_err++;
        $display("FAIL grant_timeout vec %0d: no ready after %0d cycles, expected ready", i, w);
      end else begin
        chk("grant_delay", w, 32'd0);
        push_exp(vecs[i].id, vecs[i].res, vecs[i].z, vecs[i].lt, vecs[i].gt);
      end
      @(posedge clk); #1;
      clr_req(vecs[i].id);
      drain();
    end

    // Both requesters valid continuously.
    @(posedge clk); #1;
    drive_req(1'b0, 32'd10, 32'd4, 4'h2);
    drive_req(1'b1, 32'd7,  32'd9, 4'h6);
    last_t = 0;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!(bus.req0_ready || bus.req1_ready) && w < 8);
      if (!(bus.req0_ready || bus.req1_ready)) begin
        n_vec++; n_err++;
        $display("FAIL both_valid_timeout grant %0d: none, expected a grant", k);
        break;
      end
      g = bus.req1_ready;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 1);
`else
      exp_g = 1'b0;
`endif
      chk("both_valid_grant", {31'd0, g}, {31'd0, exp_g});
      if (k > 0) chk("both_valid_spacing", cyc - last_t, 32'd2);
      last_t = cyc;
      m = g ? alu_f(32'd7, 32'd9, 4'h6) : alu_f(32'd10, 32'd4, 4'h2);
      push_exp(g, m.result, m.zero, m.blt, m.bgt);
    end
    @(posedge clk); #1;
    clr_req(1'b0);
    clr_req(1'b1);
    drain();

    // req0 pulses valid for one cycle during EXEC and must be ignored.
    @(posedge clk); #1;
    drive_req(1'b1, 32'd20, 32'd5, 4'h6);
    @(negedge clk);
    chk("exec_seq_hs_ready1", {31'd0, bus.req1_ready}, 32'd1);
    if (bus.req1_ready) push_exp(1'b1, 32'd15, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    clr_req(1'b1);
    drive_req(1'b0, 32'd1, 32'd1, 4'h2);
    @(negedge clk);
    chk("exec_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("exec_busy", {31'd0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    clr_req(1'b0);
    drain();
    cnt0 = resp_cnt;
    repeat (4) @(negedge clk);
    chk("withdrawn_no_resp", resp_cnt, cnt0);

    // Reset asserted during EXEC aborts the operation.
    @(posedge clk); #1;
    drive_req(1'b0, 32'd9, 32'd4, 4'h2);
    @(negedge clk);
    chk("abort_hs_ready0", {31'd0, bus.req0_ready}, 32'd1);
    cnt0 = resp_cnt;
    @(posedge clk); #1;
    clr_req(1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy_in_reset", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_result", bus.resp_result, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_resp", resp_cnt, cnt0);
    @(posedge clk); #1;
    drive_req(1'b1, 32'd2, 32'd2, 4'h2);
    @(negedge clk);
    chk("after_abort_ready1", {31'd0, bus.req1_ready}, 32'd1);
    if (bus.req1_ready) push_exp(1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    clr_req(1'b1);
    drain();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
